// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the PIC interrupt front end.
package pic_pkg;
  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} inta_state_t;
  localparam int PIC_LEVEL_W = 3;
  localparam logic [PIC_LEVEL_W-1:0] PIC_SPURIOUS_LEVEL = 3'd7;
endpackage

// File: rtl/pic_rotating_encoder.sv
// pic_rotating_encoder: picks the highest-priority set bit, where priority starts at lowest+1 and wraps.
module pic_rotating_encoder
  import pic_pkg::*;
(
  input  logic [7:0]             vec,
  input  logic [PIC_LEVEL_W-1:0] lowest,
  output logic [PIC_LEVEL_W-1:0] idx,
  output logic                   valid
);
  logic [7:0] rot;
  logic [PIC_LEVEL_W-1:0] k;
  // rot[k] holds the bit that is k steps after the highest-priority slot
  assign rot = 8'({vec, vec} >> ({1'b0, lowest} + 4'd1));
  always_comb begin
    k = '0;
    for (int i = 7; i >= 0; i--) k = rot[i] ? PIC_LEVEL_W'(i) : k;
  end
  assign valid = |vec;
  assign idx = lowest + 3'd1 + k;
endmodule

// File: rtl/pic_irq_priority.sv
// pic_irq_priority: 8259 IRR capture, masking, rotating/nested priority, INTA tracking and EOI.
// Define IRQ_SYNC_EN to pass each ir line through a 2-flop synchronizer.
module pic_irq_priority
  import pic_pkg::*;
#(
  parameter int NUM_IR = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_IR-1:0]      ir,
  input  logic                   ltim,
  input  logic [NUM_IR-1:0]      imr,
  input  logic                   aeoi,
  input  logic                   inta_n,
  input  logic                   eoi_valid,
  input  logic                   eoi_specific,
  input  logic [PIC_LEVEL_W-1:0] eoi_level,
  input  logic                   eoi_rotate,
  output logic [NUM_IR-1:0]      irr,
  output logic [NUM_IR-1:0]      isr,
  output logic                   int_req,
  output logic [PIC_LEVEL_W-1:0] ack_level,
  output logic [1:0]             ack_phase
);
  logic [NUM_IR-1:0] ir_s, ir_q, cand, ack_set, isr_clr;
  logic [PIC_LEVEL_W-1:0] lowest, w_idx, s_idx, w_rank, s_rank, eoi_tgt;
  logic w_valid, s_valid, win, inta_q, inta_qq, fall, rise, do_ack, do_aeoi, do_eoi;
  inta_state_t state;
`ifdef IRQ_SYNC_EN
  logic [NUM_IR-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {sync2, sync1} <= '0;
    else {sync2, sync1} <= {sync1, ir};
  assign ir_s = sync2;
`else
  assign ir_s = ir;
`endif
  assign cand = irr & ~imr;
  pic_rotating_encoder u_irr_enc (.vec(cand), .lowest(lowest), .idx(w_idx), .valid(w_valid));
  pic_rotating_encoder u_isr_enc (.vec(isr), .lowest(lowest), .idx(s_idx), .valid(s_valid));
  // rank 0 is the highest priority under the current rotation
  assign w_rank = w_idx - lowest - 3'd1;
  assign s_rank = s_idx - lowest - 3'd1;
  assign win = w_valid && (!s_valid || w_rank < s_rank);
  assign fall = inta_qq & ~inta_q;
  assign rise = ~inta_qq & inta_q;
  assign do_ack = state == IDLE && fall && win;
  assign do_aeoi = state == ACK2 && rise && aeoi;
  assign do_eoi = eoi_valid && s_valid;
  assign eoi_tgt = eoi_specific ? eoi_level : s_idx;
  assign ack_set = do_ack ? NUM_IR'(1) << w_idx : '0;
  assign isr_clr = (do_aeoi ? NUM_IR'(1) << ack_level : '0) | (do_eoi ? NUM_IR'(1) << eoi_tgt : '0);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q <= '0;
      irr <= '0;
      isr <= '0;
      int_req <= 1'b0;
      ack_level <= PIC_SPURIOUS_LEVEL;
      ack_phase <= 2'd0;
      lowest <= 3'd7;
      state <= IDLE;
      inta_q <= 1'b1;
      inta_qq <= 1'b1;
    end else begin
      ir_q <= ir_s;
      {inta_qq, inta_q} <= {inta_q, inta_n};
      irr <= ir_s & (ltim ? '1 : irr | (ir_s & ~ir_q)) & ~ack_set;
      isr <= (isr & ~isr_clr) | ack_set;
      if (do_eoi && eoi_rotate) lowest <= eoi_tgt;
      else if (do_aeoi && eoi_rotate) lowest <= ack_level;
      int_req <= state == IDLE && !fall && win;
      case (state)
        IDLE: if (fall) begin
          state <= ACK1;
          ack_phase <= 2'd1;
          ack_level <= win ? w_idx : PIC_SPURIOUS_LEVEL;
        end
        ACK1: if (rise) state <= WAIT2;
        WAIT2: if (fall) begin
          state <= ACK2;
          ack_phase <= 2'd2;
        end
        ACK2: if (rise) begin
          state <= IDLE;
          ack_phase <= 2'd0;
        end
      endcase
    end
  end
endmodule
